// File: rtl/gw2a_ddr3_pkg.sv
// Shared types for the GW2A DDR3 read-capture calibration sequencer.
package gw2a_ddr3_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_TEST,
        ST_EVAL,
        ST_STEP,
        ST_FINISH,
        ST_CENTER,
        ST_RELOAD,
        ST_DONE
    } cal_state_t;

    // DQS read-delay step direction
    localparam logic RDIR_INC = 1'b0;
    localparam logic RDIR_DEC = 1'b1;

endpackage

// File: rtl/gw2a_dqs_window_track.sv
// Per-lane passing-window tracker: follows the current run of matching taps
// and keeps the longest one seen (first one wins on a tie).
module gw2a_dqs_window_track
    import gw2a_ddr3_pkg::*;
#(
    parameter int STEP_BITS  = 7,
    parameter int MIN_WINDOW = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 eval,
    input  logic                 finish,
    input  logic                 match,
    input  logic [STEP_BITS-1:0] pos,
    output logic [STEP_BITS-1:0] best_start,
    output logic [STEP_BITS:0]   best_len,
    output logic                 fail,
    output logic [STEP_BITS-1:0] target
);

    localparam logic [STEP_BITS:0] LEN_ONE = (STEP_BITS+1)'(1);
    localparam logic [STEP_BITS:0] MIN_LEN = (STEP_BITS+1)'(MIN_WINDOW);

    logic                 open;
    logic [STEP_BITS-1:0] cur_start;
    logic [STEP_BITS:0]   cur_len;
    logic [STEP_BITS-1:0] half_len;

    // Open/extend on a match, close on a mismatch or at the end of the sweep;
    // strictly-greater keeps the lowest window when lengths tie.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            open       <= 1'b0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (eval && match) begin
            if (!open) begin
                open      <= 1'b1;
                cur_start <= pos;
                cur_len   <= LEN_ONE;
            end else begin
                cur_len <= cur_len + LEN_ONE;
            end
        end else if ((eval && !match) || finish) begin
            if (open) begin
                open <= 1'b0;
                if (cur_len > best_len) begin
                    best_start <= cur_start;
                    best_len   <= cur_len;
                end
            end
        end
    end

    assign half_len = STEP_BITS'((best_len - LEN_ONE) >> 1);
    assign target   = best_start + half_len;
    assign fail     = (best_len < MIN_LEN);

endmodule

// File: rtl/gw2a_ddr3_dqs_rdcal.sv
// Multi-lane DQS read-delay calibration: sweeps every tap, records the widest
// passing window per lane, then walks each passing lane back to its centre.
//
//   state  | meaning
//   IDLE   | waiting for cal_start_i
//   LOAD   | reload all lanes to tap 0, clear trackers
//   SETTLE | let the delay line settle after a load/move
//   TEST   | hold rd_req_o until the test read is acknowledged
//   EVAL   | feed the latched match into the window trackers
//   STEP   | increment every lane by one tap
//   FINISH | close open windows, arm per-lane centring cursors
//   CENTER | decrement passing lanes that are still above target
//   RELOAD | reset failing lanes to tap 0
//   DONE   | results valid, waiting for a new start
module gw2a_ddr3_dqs_rdcal
    import gw2a_ddr3_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int STEPS      = 128,
    parameter int STEP_BITS  = 7,
    parameter int SETTLE     = 4,
    parameter int MIN_WINDOW = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cal_start_i,
    output logic                         cal_busy_o,
    output logic                         cal_done_o,
    output logic [LANES-1:0]             cal_fail_o,
    output logic                         rd_req_o,
    input  logic                         rd_ack_i,
    input  logic [LANES-1:0]             rd_match_i,
    output logic [LANES-1:0]             dqs_rloadn_o,
    output logic [LANES-1:0]             dqs_rmove_o,
    output logic [LANES-1:0]             dqs_rdir_o,
    output logic [LANES*STEP_BITS-1:0]   lane_delay_o
);

    localparam int                    CNT_BITS    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_BITS-1:0]   SETTLE_LOAD = CNT_BITS'(SETTLE - 1);
    localparam logic [CNT_BITS-1:0]   CNT_ONE     = CNT_BITS'(1);
    localparam logic [STEP_BITS-1:0]  LAST_POS    = STEP_BITS'(STEPS - 1);
    localparam logic [STEP_BITS-1:0]  POS_ONE     = STEP_BITS'(1);

    cal_state_t state, state_nx;

    logic [CNT_BITS-1:0]                  settle_cnt;
    logic [STEP_BITS-1:0]                 pos;
    logic                                 centre;
    logic [LANES-1:0]                     match_q;
    logic [LANES-1:0][STEP_BITS-1:0]      cursor;
    logic [LANES-1:0][STEP_BITS-1:0]      target;
    logic [LANES-1:0][STEP_BITS-1:0]      best_start;
    logic [LANES-1:0][STEP_BITS:0]        best_len;
    logic [LANES-1:0]                     fail;
    logic [LANES-1:0]                     lane_ok;
    logic [LANES-1:0]                     move;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gw2a_dqs_window_track #(
            .STEP_BITS  (STEP_BITS),
            .MIN_WINDOW (MIN_WINDOW)
        ) u_track (
            .clock      (clock),
            .reset      (reset),
            .clear      (state == ST_LOAD),
            .eval       (state == ST_EVAL),
            .finish     (state == ST_FINISH),
            .match      (match_q[i]),
            .pos        (pos),
            .best_start (best_start[i]),
            .best_len   (best_len[i]),
            .fail       (fail[i]),
            .target     (target[i])
        );
    end

    // A lane with no window at all never passes, even with MIN_WINDOW = 0;
    // a lane is stepped down only while it sits above both target and window start.
    always_comb begin
        lane_ok = '0;
        move    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ok[i] = !fail[i] && (best_len[i] != '0);
            move[i]    = lane_ok[i] && (cursor[i] > target[i]) && (cursor[i] > best_start[i]);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state and pulse outputs
    always_comb begin
        state_nx     = state;
        cal_busy_o   = 1'b1;
        cal_done_o   = 1'b0;
        rd_req_o     = 1'b0;
        dqs_rloadn_o = '1;
        dqs_rmove_o  = '0;
        case (state)
            ST_IDLE: begin
                cal_busy_o = 1'b0;
                if (cal_start_i) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                dqs_rloadn_o = '0;
                state_nx     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_nx = centre ? ST_CENTER : ST_TEST;
            end
            ST_TEST: begin
                rd_req_o = 1'b1;
                if (rd_ack_i) state_nx = ST_EVAL;
            end
            ST_EVAL: begin
                state_nx = (pos == LAST_POS) ? ST_FINISH : ST_STEP;
            end
            ST_STEP: begin
                dqs_rmove_o = '1;
                state_nx    = ST_SETTLE;
            end
            ST_FINISH: begin
                state_nx = ST_CENTER;
            end
            ST_CENTER: begin
                dqs_rmove_o = move;
                state_nx    = (|move) ? ST_SETTLE : ST_RELOAD;
            end
            ST_RELOAD: begin
                dqs_rloadn_o = lane_ok;
                state_nx     = ST_DONE;
            end
            ST_DONE: begin
                cal_busy_o = 1'b0;
                cal_done_o = 1'b1;
                if (cal_start_i) state_nx = ST_LOAD;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Direction comes from a registered phase flag so it is already settled
    // the cycle before the first decrement and stays put after the last one.
    assign dqs_rdir_o = {LANES{centre ? RDIR_DEC : RDIR_INC}};

    // Settle timer, tap position, read-result latch, centring cursors, results
    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt   <= '0;
            pos          <= '0;
            centre       <= 1'b0;
            match_q      <= '0;
            cursor       <= '0;
            cal_fail_o   <= '0;
            lane_delay_o <= '0;
        end else begin
            if (state_nx == ST_SETTLE && state != ST_SETTLE) settle_cnt <= SETTLE_LOAD;
            else if (settle_cnt != '0)                       settle_cnt <= settle_cnt - CNT_ONE;

            if (state == ST_LOAD)      pos <= '0;
            else if (state == ST_STEP) pos <= pos + POS_ONE;

            if (state == ST_TEST && rd_ack_i) match_q <= rd_match_i;

            if (state_nx == ST_FINISH)                           centre <= 1'b1;
            else if (state_nx == ST_DONE || state == ST_LOAD)    centre <= 1'b0;

            for (int i = 0; i < LANES; i++) begin
                if (state == ST_FINISH)                  cursor[i] <= LAST_POS;
                else if (state == ST_CENTER && move[i])  cursor[i] <= cursor[i] - POS_ONE;
            end

            if ((state == ST_IDLE || state == ST_DONE) && cal_start_i) begin
                cal_fail_o <= '0;
            end else if (state == ST_RELOAD) begin
                cal_fail_o <= ~lane_ok;
                for (int i = 0; i < LANES; i++)
                    lane_delay_o[i*STEP_BITS +: STEP_BITS] <= lane_ok[i] ? target[i] : '0;
            end
        end
    end

endmodule
